// File: rtl/pending_decoder_pkg.sv
// Shared definitions for the pending decoder and its companion priority encoder.
package pending_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    function automatic int out_width(input int in_width);
        return 1 << in_width;
    endfunction

endpackage

// File: rtl/pending_decoder_onehot_decode.sv
// Pure combinational index-to-one-hot decoder; reusable by other blocks.
module onehot_decode
    import pending_decoder_pkg::*;
#(
    parameter  int IN_WIDTH  = 3,
    localparam int OUT_WIDTH = out_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  index,
    output logic [OUT_WIDTH-1:0] onehot
);

    always_comb begin
        onehot = OUT_WIDTH'(1) << index;
    end

endmodule

// File: rtl/pending_decoder.sv
// Sequential index-to-one-hot walker feeding a sticky pending mask.
// state | meaning
// IDLE  | no run in progress; strobe and done are low, ready for a request
// WALK  | strobing onehot(cursor); done on the cycle where remaining == 0
module pending_decoder
    import pending_decoder_pkg::*;
#(
    parameter  int IN_WIDTH  = 3,
    localparam int OUT_WIDTH = out_width(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_index,
    input  logic [IN_WIDTH-1:0]  in_len,
    input  logic [OUT_WIDTH-1:0] clr,
    output logic [OUT_WIDTH-1:0] strobe,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] pending,
    output logic                 pending_any
);

    state_t                state, state_nxt;
    logic [IN_WIDTH-1:0]   cursor, cursor_nxt;
    logic [IN_WIDTH-1:0]   remaining, remaining_nxt;
    logic [OUT_WIDTH-1:0]  cursor_onehot;
    logic                  accept;

    onehot_decode #(.IN_WIDTH(IN_WIDTH)) u_decode (
        .index  (cursor),
        .onehot (cursor_onehot)
    );

    // rst gates ready combinationally so nothing is accepted while held in reset
    assign in_ready    = !rst && ((state == IDLE) || (remaining == '0));
    assign accept      = in_valid && in_ready;
    assign done        = (state == WALK) && (remaining == '0);
    assign strobe      = (state == WALK) ? cursor_onehot : '0;
    assign pending_any = |pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cursor    <= '0;
            remaining <= '0;
            pending   <= '0;
        end else begin
            state     <= state_nxt;
            cursor    <= cursor_nxt;
            remaining <= remaining_nxt;
            // set wins over a same-cycle clear
            pending   <= (pending & ~clr) | strobe;
        end
    end

    always_comb begin
        state_nxt     = state;
        cursor_nxt    = cursor;
        remaining_nxt = remaining;
        if (state == WALK) begin
            cursor_nxt = cursor + IN_WIDTH'(1);
            if (remaining != '0) begin
                remaining_nxt = remaining - IN_WIDTH'(1);
            end else begin
                state_nxt = IDLE;
            end
        end
        // a request accepted on the done edge re-enters WALK without a bubble
        if (accept) begin
            state_nxt     = WALK;
            cursor_nxt    = in_index;
            remaining_nxt = in_len;
        end
    end

endmodule

// File: tb/tb_pending_decoder.sv
// Directed self-checking bench for pending_decoder with IN_WIDTH=3.
module tb_pending_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_index = '0;
    logic [2:0] in_len = '0;
    logic [7:0] clr = '0;
    logic [7:0] strobe;
    logic       done;
    logic [7:0] pending;
    logic       pending_any;

    int pass_cnt = 0;
    int total_cnt = 0;

    pending_decoder #(.IN_WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_index    (in_index),
        .in_len      (in_len),
        .clr         (clr),
        .strobe      (strobe),
        .done        (done),
        .pending     (pending),
        .pending_any (pending_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        total_cnt++;
        if (pending !== 8'h00) $display("FAIL reset_pending got %h want 00", pending); else pass_cnt++;
        total_cnt++;
        if (strobe !== 8'h00) $display("FAIL reset_strobe got %h want 00", strobe); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++;
        if (pending_any !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_any_done got %b%b want 00", pending_any, done);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_index = 3'd5; in_len = 3'd0;
        tick();
        in_valid = 1'b0; in_index = 3'd2; in_len = 3'd7;
        total_cnt++;
        if (strobe !== 8'h20) $display("FAIL single_strobe got %h want 20", strobe); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1) $display("FAIL single_done got %b want 1", done); else pass_cnt++;
        total_cnt++;
        if (pending !== 8'h00) $display("FAIL single_pending_early got %h want 00", pending); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 8'h20) $display("FAIL single_pending got %h want 20", pending); else pass_cnt++;
        total_cnt++;
        if (pending_any !== 1'b1) $display("FAIL single_any got %b want 1", pending_any); else pass_cnt++;
        total_cnt++;
        if (strobe !== 8'h00 || done !== 1'b0)
            $display("FAIL single_idle got strobe %h done %b want 00 0", strobe, done);
        else pass_cnt++;
        clr = 8'h20;
        tick();
        clr = 8'h00;
        total_cnt++;
        if (pending !== 8'h00 || pending_any !== 1'b0)
            $display("FAIL single_clear got %h/%b want 00/0", pending, pending_any);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_s [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
        in_valid = 1'b1; in_index = 3'd6; in_len = 3'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (strobe !== exp_s[i]) $display("FAIL wrap_strobe[%0d] got %h want %h", i, strobe, exp_s[i]);
            else pass_cnt++;
            total_cnt++;
            if (done !== (i == 3)) $display("FAIL wrap_done[%0d] got %b want %b", i, done, (i == 3));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (pending !== 8'hC3) $display("FAIL wrap_pending got %h want c3", pending); else pass_cnt++;
        total_cnt++;
        if (strobe !== 8'h00) $display("FAIL wrap_idle_strobe got %h want 00", strobe); else pass_cnt++;
    endtask

    task automatic test_collision();
        in_valid = 1'b1; in_index = 3'd6; in_len = 3'd0;
        tick();
        in_valid = 1'b0;
        clr = 8'h40;
        total_cnt++;
        if (strobe !== 8'h40) $display("FAIL coll_strobe got %h want 40", strobe); else pass_cnt++;
        tick();
        clr = 8'h00;
        total_cnt++;
        if (pending !== 8'hC3) $display("FAIL coll_set_wins got %h want c3", pending); else pass_cnt++;
        clr = 8'h02;
        tick();
        clr = 8'h00;
        total_cnt++;
        if (pending !== 8'hC1) $display("FAIL coll_clear got %h want c1", pending); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 8'hC1) $display("FAIL coll_sticky got %h want c1", pending); else pass_cnt++;
        clr = 8'hFF;
        tick();
        clr = 8'h00;
        total_cnt++;
        if (pending !== 8'h00) $display("FAIL coll_clear_all got %h want 00", pending); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_index = 3'd4; in_len = 3'd1;
        tick();
        total_cnt++;
        if (strobe !== 8'h10 || done !== 1'b0)
            $display("FAIL b2b_first got strobe %h done %b want 10 0", strobe, done);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_busy_ready got %b want 0", in_ready); else pass_cnt++;
        in_index = 3'd7; in_len = 3'd2;
        tick();
        total_cnt++;
        if (strobe !== 8'h20 || done !== 1'b1)
            $display("FAIL b2b_second got strobe %h done %b want 20 1", strobe, done);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_done_ready got %b want 1", in_ready); else pass_cnt++;
        in_index = 3'd0; in_len = 3'd1;
        tick();
        in_valid = 1'b0; in_index = 3'd7; in_len = 3'd7;
        total_cnt++;
        if (strobe !== 8'h01 || done !== 1'b0)
            $display("FAIL b2b_no_bubble got strobe %h done %b want 01 0", strobe, done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (strobe !== 8'h02 || done !== 1'b1)
            $display("FAIL b2b_last got strobe %h done %b want 02 1", strobe, done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (strobe !== 8'h00 || pending !== 8'h33)
            $display("FAIL b2b_end got strobe %h pending %h want 00 33", strobe, pending);
        else pass_cnt++;
        clr = 8'hFF;
        tick();
        clr = 8'h00;
    endtask

    task automatic test_full_ring();
        logic [7:0] exp_s;
        in_valid = 1'b1; in_index = 3'd3; in_len = 3'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_s = 8'h01 << ((3 + i) % 8);
            total_cnt++;
            if (strobe !== exp_s || done !== (i == 7))
                $display("FAIL ring_step[%0d] got strobe %h done %b want %h %b", i, strobe, done, exp_s, (i == 7));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (pending !== 8'hFF) $display("FAIL ring_pending got %h want ff", pending); else pass_cnt++;
        clr = 8'hFF;
        tick();
        clr = 8'h00;

        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (strobe !== 8'h08) $display("FAIL midrst_strobe0 got %h want 08", strobe); else pass_cnt++;
        tick();
        total_cnt++;
        if (strobe !== 8'h10 || pending !== 8'h08)
            $display("FAIL midrst_strobe1 got strobe %h pending %h want 10 08", strobe, pending);
        else pass_cnt++;
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (strobe !== 8'h00 || done !== 1'b0)
            $display("FAIL midrst_strobe got strobe %h done %b want 00 0", strobe, done);
        else pass_cnt++;
        total_cnt++;
        if (pending !== 8'h00 || pending_any !== 1'b0)
            $display("FAIL midrst_pending got %h/%b want 00/0", pending, pending_any);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", in_ready); else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midrst_release_ready got %b want 1", in_ready); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if (strobe !== 8'h00 || pending !== 8'h00)
                $display("FAIL midrst_quiet[%0d] got strobe %h pending %h want 00 00", i, strobe, pending);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_collision();
        test_back_to_back();
        test_full_ring();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
